// File: rtl/lzrw1_group_packer_pkg.sv
// Shared types, default geometry and the copy-token encoder for the LZRW1 group packer.
// Optional statistics counters are enabled by defining LZRW1_PACK_STATS_EN.
package lzrw1_pkg;

    localparam int GROUP_ITEMS_DEFAULT = 16;
    localparam int LEN_W_DEFAULT       = 4;
    localparam int OFF_W_DEFAULT       = 12;
    localparam int MIN_MATCH_DEFAULT   = 3;

    localparam int CTRL_BYTES    = GROUP_ITEMS_DEFAULT / 8;
    localparam int PAYLOAD_BYTES = 2 * GROUP_ITEMS_DEFAULT;

    typedef enum logic [1:0] {
        FILL,
        EMIT_CTRL,
        EMIT_DATA
    } pack_state_t;

    // "byte" is a keyword, so the literal value lives in the data field.
    typedef struct packed {
        logic        copy;
        logic [7:0]  data;
        logic [7:0]  length;
        logic [15:0] offset;
        logic        last;
    } item_t;

    // Copy token: length code in the top len_w bits, offset in the rest.
    function automatic logic [15:0] encode_copy(
        input logic [7:0]  length,
        input logic [15:0] offset,
        input int          len_w     = LEN_W_DEFAULT,
        input int          min_match = MIN_MATCH_DEFAULT
    );
        logic [15:0] code;
        logic [15:0] mask;
        code = 16'(length) - 16'(min_match);
        mask = (16'h1 << (16 - len_w)) - 16'h1;
        return (code << (16 - len_w)) | (offset & mask);
    endfunction

endpackage

// File: rtl/lzrw1_group_packer_if.sv
// Item-in / byte-out handshake bundle for the LZRW1 group packer.
// The packer connects through the slave modport; the producer/consumer side uses master.
interface lzrw1_group_packer_if
    import lzrw1_pkg::*;
#(
    parameter int OFF_W = OFF_W_DEFAULT
) ();
    logic             in_valid;
    logic             in_ready;
    logic             in_copy;
    logic [7:0]       in_byte;
    logic [7:0]       in_length;
    logic [OFF_W-1:0] in_offset;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_byte;
    logic             out_last;
    logic             err;

    modport master (
        output in_valid, in_copy, in_byte, in_length, in_offset, in_last, out_ready,
        input  in_ready, out_valid, out_byte, out_last, err
    );

    modport slave (
        input  in_valid, in_copy, in_byte, in_length, in_offset, in_last, out_ready,
        output in_ready, out_valid, out_byte, out_last, err
    );
endinterface

// File: rtl/lzrw1_group_packer_encoder.sv
// Combinational legality check and byte encoding of one compressor item.
// nbytes is 1 for a literal, 2 for a legal copy and 0 for an illegal (dropped) copy.
module lzrw1_item_encoder
    import lzrw1_pkg::*;
#(
    parameter int LEN_W     = LEN_W_DEFAULT,
    parameter int MIN_MATCH = MIN_MATCH_DEFAULT
) (
    input  logic        copy,
    input  logic [7:0]  data,
    input  logic [7:0]  length,
    input  logic [15:0] offset,
    output logic        legal,
    output logic [1:0]  nbytes,
    output logic [7:0]  b0,
    output logic [7:0]  b1
);
    logic [31:0] len32;
    logic [15:0] code;

    // Classify the item and produce its payload bytes.
    always_comb begin
        len32  = {24'd0, length};
        code   = encode_copy(length, offset, LEN_W, MIN_MATCH);
        legal  = 1'b1;
        nbytes = 2'd1;
        b0     = data;
        b1     = 8'h00;
        if (copy) begin
            legal  = (len32 >= 32'(MIN_MATCH)) &&
                     (len32 <= 32'(MIN_MATCH + (1 << LEN_W) - 1)) &&
                     (offset != 16'h0000);
            nbytes = legal ? 2'd2 : 2'd0;
            b0     = code[15:8];
            b1     = code[7:0];
        end
    end
endmodule

// File: rtl/lzrw1_group_packer.sv
// LZRW1 group packer: collects items into a group buffer, then streams the
// control bytes followed by the payload bytes with valid/ready backpressure.
// Define LZRW1_PACK_STATS_EN to add saturating 32-bit statistics outputs.
module lzrw1_group_packer
    import lzrw1_pkg::*;
#(
    parameter int GROUP_ITEMS = GROUP_ITEMS_DEFAULT,
    parameter int LEN_W       = LEN_W_DEFAULT,
    parameter int OFF_W       = OFF_W_DEFAULT,
    parameter int MIN_MATCH   = MIN_MATCH_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    lzrw1_group_packer_if.slave bus
`ifdef LZRW1_PACK_STATS_EN
    ,
    output logic [31:0] stat_literals,
    output logic [31:0] stat_copies,
    output logic [31:0] stat_bytes_out,
    output logic [31:0] stat_groups
`endif
);
    localparam int CTRL_N = GROUP_ITEMS / 8;
    localparam int PAY_N  = 2 * GROUP_ITEMS;
    localparam int PW     = $clog2(CTRL_N + PAY_N + 1);
    localparam int AW     = $clog2(PAY_N);
    localparam int IW     = $clog2(GROUP_ITEMS);

    pack_state_t      state_reg, state_next;
    logic [IW-1:0]    count_reg, count_next;
    logic [GROUP_ITEMS-1:0] ctrl_reg, ctrl_next;
    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    pos_reg, pos_next;
    logic [PW-1:0]    total;
    logic             last_grp_reg, last_grp_next;
    logic             err_reg, err_next;
    logic             out_valid_reg, out_valid_next;
    logic             out_last_reg, out_last_next;
    logic             in_ready_reg;
    logic [7:0]       out_byte_reg;
    logic [7:0]       ctrl_byte;
    logic [AW-1:0]    rd_idx;
    logic [AW-1:0]    wr1_addr;
    logic [7:0]       payload_mem [PAY_N];

    item_t            item;
    logic             enc_legal;
    logic [1:0]       enc_n;
    logic [7:0]       enc_b0, enc_b1;
    logic             accept_in, accept_out;
    logic             wr0_en, wr1_en, load_en, load_data, grp_done;

    assign item = '{copy:   bus.in_copy,
                    data:   bus.in_byte,
                    length: bus.in_length,
                    offset: {{(16 - OFF_W){1'b0}}, bus.in_offset},
                    last:   bus.in_last};

    assign accept_in  = in_ready_reg && bus.in_valid;
    assign accept_out = out_valid_reg && bus.out_ready;
    assign wr1_addr   = wr_ptr_reg[AW-1:0] + AW'(1);

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_byte  = out_byte_reg;
    assign bus.out_last  = out_last_reg;
    assign bus.err       = err_reg;

    lzrw1_item_encoder #(
        .LEN_W     (LEN_W),
        .MIN_MATCH (MIN_MATCH)
    ) u_encoder (
        .copy   (item.copy),
        .data   (item.data),
        .length (item.length),
        .offset (item.offset),
        .legal  (enc_legal),
        .nbytes (enc_n),
        .b0     (enc_b0),
        .b1     (enc_b1)
    );

    // Next-state logic: fill the group, then walk the output position over ctrl and payload bytes.
    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        ctrl_next      = ctrl_reg;
        wr_ptr_next    = wr_ptr_reg;
        pos_next       = pos_reg;
        last_grp_next  = last_grp_reg;
        err_next       = err_reg;
        out_valid_next = out_valid_reg;
        out_last_next  = out_last_reg;
        wr0_en         = 1'b0;
        wr1_en         = 1'b0;
        load_en        = 1'b0;
        load_data      = 1'b0;
        grp_done       = 1'b0;
        rd_idx         = '0;
        ctrl_byte      = 8'h00;
        total          = PW'(CTRL_N) + wr_ptr_reg;
        case (state_reg)
            FILL: begin
                if (accept_in) begin
                    if (!enc_legal) begin
                        err_next = 1'b1;
                    end
                    if (enc_n != 2'd0) begin
                        wr0_en               = 1'b1;
                        wr1_en               = (enc_n == 2'd2);
                        ctrl_next[count_reg] = item.copy;
                        count_next           = count_reg + IW'(1);
                        wr_ptr_next          = wr_ptr_reg + PW'(enc_n);
                    end
                    // A full group and in_last on the same item still close only once.
                    if (item.last || (enc_legal && count_reg == IW'(GROUP_ITEMS - 1))) begin
                        total          = PW'(CTRL_N) + wr_ptr_next;
                        state_next     = EMIT_CTRL;
                        last_grp_next  = item.last;
                        out_valid_next = 1'b1;
                        pos_next       = '0;
                        load_en        = 1'b1;
                        out_last_next  = item.last && (total == PW'(1));
                    end
                end
            end
            default: begin
                if (accept_out) begin
                    pos_next = pos_reg + PW'(1);
                    if (pos_next == total) begin
                        state_next     = FILL;
                        out_valid_next = 1'b0;
                        out_last_next  = 1'b0;
                        count_next     = '0;
                        ctrl_next      = '0;
                        wr_ptr_next    = '0;
                        pos_next       = '0;
                        last_grp_next  = 1'b0;
                        grp_done       = 1'b1;
                    end else begin
                        load_en       = 1'b1;
                        load_data     = (pos_next >= PW'(CTRL_N));
                        state_next    = load_data ? EMIT_DATA : EMIT_CTRL;
                        rd_idx        = AW'(pos_next - PW'(CTRL_N));
                        out_last_next = last_grp_reg && (pos_next == total - PW'(1));
                    end
                end
            end
        endcase
        for (int k = 0; k < CTRL_N; k++) begin
            if (pos_next == PW'(k)) begin
                ctrl_byte = ctrl_next[8*k +: 8];
            end
        end
    end

    // Control and state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= FILL;
            count_reg     <= '0;
            ctrl_reg      <= '0;
            wr_ptr_reg    <= '0;
            pos_reg       <= '0;
            last_grp_reg  <= 1'b0;
            err_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            in_ready_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            ctrl_reg      <= ctrl_next;
            wr_ptr_reg    <= wr_ptr_next;
            pos_reg       <= pos_next;
            last_grp_reg  <= last_grp_next;
            err_reg       <= err_next;
            out_valid_reg <= out_valid_next;
            out_last_reg  <= out_last_next;
            in_ready_reg  <= (state_next == FILL);
        end
    end

    // Payload buffer writes; a copy lands as two consecutive bytes.
    always_ff @(posedge clock) begin
        if (wr0_en) begin
            payload_mem[wr_ptr_reg[AW-1:0]] <= enc_b0;
        end
        if (wr1_en) begin
            payload_mem[wr1_addr] <= enc_b1;
        end
    end

    // Output byte register doubles as the registered read of the payload buffer.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_byte_reg <= 8'h00;
        end else if (load_en) begin
            out_byte_reg <= load_data ? payload_mem[rd_idx] : ctrl_byte;
        end
    end

`ifdef LZRW1_PACK_STATS_EN
    logic [3:0] stat_inc;
    assign stat_inc = {grp_done, accept_out,
                       accept_in && (enc_n == 2'd2),
                       accept_in && (enc_n == 2'd1)};

    for (genvar gi = 0; gi < 4; gi++) begin : g_stat
        logic [31:0] cnt_reg;
        // Saturating event counter.
        always_ff @(posedge clock) begin
            if (reset) begin
                cnt_reg <= '0;
            end else if (stat_inc[gi] && (cnt_reg != '1)) begin
                cnt_reg <= cnt_reg + 32'd1;
            end
        end
    end

    assign stat_literals  = g_stat[0].cnt_reg;
    assign stat_copies    = g_stat[1].cnt_reg;
    assign stat_bytes_out = g_stat[2].cnt_reg;
    assign stat_groups    = g_stat[3].cnt_reg;
`endif
endmodule

// File: doc/lzrw1_group_packer.md
Name: lzrw1_group_packer

Overview:
- Packs the compressor's per-cycle item stream into LZRW1 groups and emits them as a byte stream with valid/ready handshake.
- Each item is either a literal byte or a copy (length, offset).
- Each group is GROUP_ITEMS control bits followed by the item payloads.
- Sits between the compressor core and the output memory/DMA. It is the parametrised successor to the fixed 16-bit control word plus compArray output: adds streaming, backpressure, partial-group flush and error flagging.

Parameters:
- GROUP_ITEMS, 16, items per group; multiple of 8, range 8..64.
- LEN_W, 4, copy length code width.
- OFF_W, 12, copy offset width; LEN_W+OFF_W must equal 16.
- MIN_MATCH, 3, smallest legal copy length; len_code = length - MIN_MATCH.

Ports:
- clock in 1: rising-edge clock.
- reset in 1: synchronous, active-high.
- in_valid in 1: item presented.
- in_ready out 1: packer accepts the item.
- in_copy in 1: 1 = copy item, 0 = literal.
- in_byte in 8: literal value; ignored for copies.
- in_length in 8: copy length.
- in_offset in OFF_W: copy offset.
- in_last in 1: final item of stream.
- out_valid out 1: output byte valid.
- out_ready in 1: downstream accepts.
- out_byte out 8: output byte.
- out_last out 1: last byte of stream.
- err out 1: sticky illegal-copy flag.

Behaviour:
- Reset (synchronous, active-high) clears all state: in_ready=0, out_valid=0, out_byte=0, out_last=0, err=0, item count=0, control bits=0, state=FILL. Reset mid-emit discards the partial group; nothing further is emitted.
- Transfer rule: an item or byte transfers when valid && ready on a clock edge. Once out_valid is asserted, out_byte and out_last hold until accepted.
- FILL state: in_ready=1. Each accepted item is written to the payload buffer (2*GROUP_ITEMS bytes) and its bit is set in ctrl[item_idx].
  - Literal: one byte, in_byte.
  - Copy: two bytes, {len_code[LEN_W-1:0], in_offset[OFF_W-1:8]} then in_offset[7:0].
- Leaving FILL: after accepting item GROUP_ITEMS-1, or any item with in_last, move to EMIT_CTRL on the next cycle. in_ready=0 in all non-FILL states; the buffer is single-banked.
- EMIT_CTRL: emit GROUP_ITEMS/8 control bytes, lowest first. Control byte k = ctrl[8k+7:8k]; bit0 = earliest item. Unused bits of a partial group are 0.
- EMIT_DATA: emit payload bytes in arrival order, then return to FILL with count and ctrl cleared.
- out_last: asserted only on the final payload byte of the group that contained in_last.
- Latency: first control byte is valid 1 cycle after the group-closing item is accepted. Throughput is 1 byte/cycle under out_ready=1.
- Illegal copy: in_copy with in_length<MIN_MATCH, in_length>MIN_MATCH+2^LEN_W-1, or in_offset==0.
  - The item is accepted but dropped: no ctrl bit, no payload, count unchanged. err is set and sticky until reset.
  - If the dropped item carried in_last, the group still closes. If that group is empty, emit GROUP_ITEMS/8 zero control bytes, with out_last on the last of them.
- Simultaneous in_last and group-full: a single close, with out_last on that group.
- out_ready low: the FSM stalls and the byte pointer holds.

Optional Feature:
- Macro: LZRW1_PACK_STATS_EN.
- Defined: adds 32-bit outputs stat_literals, stat_copies, stat_bytes_out and stat_groups. Each increments on the corresponding accepted item, output byte, or completed group; all are cleared by reset and saturate at all-ones.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package lzrw1_pkg:
  - typedef item_t struct {copy, byte, length, offset, last};
  - typedef enum pack_state_t {FILL, EMIT_CTRL, EMIT_DATA};
  - localparams CTRL_BYTES=GROUP_ITEMS/8, PAYLOAD_BYTES=2*GROUP_ITEMS;
  - function encode_copy(length, offset) returning 16 bits.
- One natural sub-module: lzrw1_item_encoder (combinational legality check plus encode, returns byte count 0/1/2 and encoded bytes), instantiated once.

Test Plan:
- 16 literals 'A'..'P', last on 'P', out_ready=1 -> 0x00,0x00,0x41..0x50 (18 bytes); out_last only on 0x50; first byte 1 cycle after 'P' accepted.
- Literal 'a', then copy(length=5, offset=0x123) with last -> 0x02,0x00,0x61,0x21,0x23; out_last on 0x23; err=0.
- Same as test 2, with out_ready toggling 1,0,0,1 repeating -> identical byte sequence, no duplicates, out_byte stable while stalled; in_ready=0 until the final byte is accepted.
- Copy(length=2, offset=0x010), then literal 0x7A with last -> err=1 sticky; output 0x00,0x00,0x7A.
- 20 items (16 literals 0x30..0x3F, then 4 copies length=3 offset=0x001, last on item 20) -> group 1 = 0x00,0x00 + 16 bytes; group 2 = 0x0F,0x00 then 0x00,0x01 repeated 4×; out_last on the final 0x01.
- Reset asserted during EMIT_DATA of test 1 (after 5 bytes) -> out_valid=0 next cycle, in_ready=1 one cycle after reset drops; new 1-literal stream 0x55 with last -> 0x00,0x00,0x55. With LZRW1_PACK_STATS_EN: stats read 1 literal, 3 bytes, 1 group.
